// File: rtl/booth_r16_encoder.sv
// rtl/booth_r16_encoder.sv - sequential radix-16 Booth digit encoder
// Scans operand B four bits per digit with a 5-bit overlapping window, LSB digit first.
package mul_pkg;
   typedef enum logic [3:0] {
      PP_0  = 4'd0,
      PP_A  = 4'd1,
      PP_2A = 4'd2,
      PP_3A = 4'd3,
      PP_4A = 4'd4,
      PP_5A = 4'd5,
      PP_6A = 4'd6,
      PP_7A = 4'd7,
      PP_8A = 4'd8
   } booth_sel_t;
endpackage

module booth_r16_encoder #(
   parameter int WIDTH = 52,
   localparam int NDIG = WIDTH / 4 + 1,
   localparam int CNTW = $clog2(NDIG)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                op_valid_i,
   output logic                op_ready_o,
   input  logic [WIDTH-1:0]    op_b_i,
   input  logic                op_signed_i,
   output logic                dig_valid_o,
   input  logic                dig_ready_i,
   output mul_pkg::booth_sel_t dig_sel_o,
   output logic                dig_neg_o,
   output logic [CNTW-1:0]     dig_idx_o,
   output logic                dig_last_o
);
   localparam int EW = 4 * NDIG;
   localparam int XW = EW - WIDTH;
   localparam logic [CNTW-1:0] LAST_IDX = CNTW'(NDIG - 1);

   typedef enum logic {
      IDLE = 1'b0,
      ENC  = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [EW-1:0]       sr_q, sr_d;
   logic                p_q, p_d;
   logic [CNTW-1:0]     idx_q, idx_d;

   logic [EW-1:0]       ext_b;
   logic                op_fire;
   logic                dig_fire;
   logic                is_last;
   logic [4:0]          win;
   logic [3:0]          pos;
   mul_pkg::booth_sel_t sel;
   logic                neg;

   always_comb begin
      ext_b    = {{XW{op_signed_i & op_b_i[WIDTH-1]}}, op_b_i};
      is_last  = (idx_q == LAST_IDX);
      op_fire  = (state_q == IDLE) && op_valid_i;
      dig_fire = (state_q == ENC) && dig_ready_i;
      state_d  = state_q;
      sr_d     = sr_q;
      p_d      = p_q;
      idx_d    = idx_q;
      if (op_fire) begin
         state_d = ENC;
         sr_d    = ext_b;
         p_d     = 1'b0;
         idx_d   = '0;
      end else if (dig_fire) begin
         p_d  = sr_q[3];
         sr_d = sr_q >> 4;
         // Index holds at the last digit rather than wrapping; it is reloaded on the next operand.
         if (is_last) begin
            state_d = IDLE;
         end else begin
            idx_d = idx_q + CNTW'(1);
         end
      end
   end

   // pos is the non-negative part 4*w3+2*w2+w1+w0 (0..8); w4 subtracts 8 from it.
   always_comb begin
      win = {sr_q[3:0], p_q};
      pos = {1'b0, win[3:1]} + {3'b000, win[0]};
      sel = mul_pkg::PP_0;
      neg = 1'b0;
      if (win[4]) begin
         if (pos != 4'd8) begin
            sel = mul_pkg::booth_sel_t'(4'd8 - pos);
            neg = 1'b1;
         end
      end else begin
         sel = mul_pkg::booth_sel_t'(pos);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sr_q    <= '0;
         p_q     <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         p_q     <= p_d;
         idx_q   <= idx_d;
      end
   end

   // Digit outputs are forced to zero outside ENC so residual shift state never leaks out.
   assign op_ready_o  = (state_q == IDLE);
   assign dig_valid_o = (state_q == ENC);
   assign dig_sel_o   = dig_valid_o ? sel : mul_pkg::PP_0;
   assign dig_neg_o   = dig_valid_o & neg;
   assign dig_idx_o   = dig_valid_o ? idx_q : '0;
   assign dig_last_o  = dig_valid_o & is_last;

endmodule

// File: tb/tb_booth_r16_encoder.sv
// tb/tb_booth_r16_encoder.sv - self-checking bench for booth_r16_encoder
// Golden digits come from rounded quotients t_i = round(V / 16^i), d_i = t_i - 16*t_(i+1).
module tb_booth_r16_encoder;
   localparam int WIDTH = 52;
   localparam int NDIG  = 14;

   logic                clk_i = 1'b0;
   logic                rst_ni;
   logic                op_valid_i;
   logic                op_ready_o;
   logic [WIDTH-1:0]    op_b_i;
   logic                op_signed_i;
   logic                dig_valid_o;
   logic                dig_ready_i;
   mul_pkg::booth_sel_t dig_sel_o;
   logic                dig_neg_o;
   logic [3:0]          dig_idx_o;
   logic                dig_last_o;

   int errors = 0;
   int checks = 0;

   logic [WIDTH-1:0] cur_b;
   logic             cur_s;
   bit               busy = 1'b0;
   int               k = 0;
   longint           acc = 0;
   int               rec_d [NDIG];

   booth_r16_encoder #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .op_valid_i (op_valid_i),
      .op_ready_o (op_ready_o),
      .op_b_i     (op_b_i),
      .op_signed_i(op_signed_i),
      .dig_valid_o(dig_valid_o),
      .dig_ready_i(dig_ready_i),
      .dig_sel_o  (dig_sel_o),
      .dig_neg_o  (dig_neg_o),
      .dig_idx_o  (dig_idx_o),
      .dig_last_o (dig_last_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint golden(input logic [WIDTH-1:0] b, input logic s);
      longint v;
      v = longint'({12'b0, b});
      if (s && b[WIDTH-1]) v = v - (longint'(1) << WIDTH);
      return v;
   endfunction

   function automatic longint tq(input longint v, input int i);
      if (i == 0) return v;
      return (v + (longint'(1) << (4 * i - 1))) >>> (4 * i);
   endfunction

   function automatic int model_digit(input logic [WIDTH-1:0] b, input logic s, input int i);
      longint v;
      v = golden(b, s);
      return int'(tq(v, i) - 16 * tq(v, i + 1));
   endfunction

   function automatic logic [11:0] pack_out();
      return {op_ready_o, dig_valid_o, 4'(dig_sel_o), dig_neg_o, dig_idx_o, dig_last_o};
   endfunction

   always @(negedge clk_i) begin
      int     ed;
      int     gd;
      longint gv;
      if (!rst_ni) begin
         check(pack_out() == 12'h800, "reset_outputs", longint'(pack_out()), 64'h800);
         busy = 1'b0;
         k    = 0;
         acc  = 0;
      end else begin
         check(op_ready_o == !busy, "op_ready", longint'(op_ready_o), longint'(!busy));
         check(dig_valid_o == busy, "dig_valid", longint'(dig_valid_o), longint'(busy));
         if (busy) begin
            ed = model_digit(cur_b, cur_s, k);
            gd = dig_neg_o ? -int'(dig_sel_o) : int'(dig_sel_o);
            check(gd == ed && !(ed == 0 && dig_neg_o), "digit", longint'(gd), longint'(ed));
            check(dig_idx_o == 4'(k), "dig_idx", longint'(dig_idx_o), longint'(k));
            check(dig_last_o == (k == NDIG - 1), "dig_last", longint'(dig_last_o), longint'(k == NDIG - 1));
            if (dig_ready_i) begin
               rec_d[k] = gd;
               acc = acc + (longint'(gd) <<< (4 * k));
               k++;
               if (k == NDIG) begin
                  gv = golden(cur_b, cur_s);
                  check(acc == gv, "reconstruct", acc, gv);
                  busy = 1'b0;
               end
            end
         end else if (op_valid_i) begin
            cur_b = op_b_i;
            cur_s = op_signed_i;
            busy  = 1'b1;
            k     = 0;
            acc   = 0;
         end
      end
   end

   task automatic start_op(input logic [WIDTH-1:0] b, input logic s);
      int budget;
      op_b_i      = b;
      op_signed_i = s;
      op_valid_i  = 1'b1;
      budget      = 0;
      while (!op_ready_o && budget < 50) begin
         @(posedge clk_i); #1;
         budget++;
      end
      check(op_ready_o, "op_accept_timeout", longint'(op_ready_o), 1);
      @(posedge clk_i); #1;
      op_valid_i = 1'b0;
   endtask

   task automatic finish_op(input bit rnd);
      int budget;
      budget = 0;
      while (!op_ready_o && budget < 200) begin
         dig_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         @(posedge clk_i); #1;
         budget++;
      end
      check(op_ready_o, "stream_timeout", longint'(op_ready_o), 1);
   endtask

   task automatic wait_idx(input int n);
      int budget;
      budget      = 0;
      dig_ready_i = 1'b1;
      while (dig_idx_o != 4'(n) && budget < 40) begin
         @(posedge clk_i); #1;
         budget++;
      end
      check(dig_idx_o == 4'(n), "reach_idx", longint'(dig_idx_o), longint'(n));
   endtask

   initial begin
      logic [WIDTH-1:0] ones;
      logic [WIDTH-1:0] rb;
      ones        = '1;
      rst_ni      = 1'b0;
      op_valid_i  = 1'b0;
      op_b_i      = '0;
      op_signed_i = 1'b0;
      dig_ready_i = 1'b0;

      check(model_digit(52'h8, 1'b0, 0) == -8, "model_b8_d0", model_digit(52'h8, 1'b0, 0), -8);
      check(model_digit(52'h8, 1'b0, 1) == 1, "model_b8_d1", model_digit(52'h8, 1'b0, 1), 1);
      check(model_digit(ones, 1'b1, 0) == -1, "model_m1_d0", model_digit(ones, 1'b1, 0), -1);
      check(model_digit(ones, 1'b1, 13) == 0, "model_m1_d13", model_digit(ones, 1'b1, 13), 0);
      check(model_digit(ones, 1'b0, 12) == 0, "model_u1_d12", model_digit(ones, 1'b0, 12), 0);
      check(model_digit(ones, 1'b0, 13) == 1, "model_u1_d13", model_digit(ones, 1'b0, 13), 1);

      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;

      start_op('0, 1'b0);
      finish_op(1'b0);
      for (int i = 0; i < NDIG; i++) check(rec_d[i] == 0, "zero_digits", rec_d[i], 0);

      start_op(52'h8, 1'b0);
      finish_op(1'b0);
      check(rec_d[0] == -8, "b8_d0", rec_d[0], -8);
      check(rec_d[1] == 1, "b8_d1", rec_d[1], 1);
      check(rec_d[2] == 0, "b8_d2", rec_d[2], 0);

      start_op(ones, 1'b1);
      finish_op(1'b0);
      check(rec_d[0] == -1, "m1_d0", rec_d[0], -1);
      check(rec_d[13] == 0, "m1_d13", rec_d[13], 0);

      start_op(ones, 1'b0);
      finish_op(1'b0);
      check(rec_d[0] == -1, "u1_d0", rec_d[0], -1);
      check(rec_d[12] == 0, "u1_d12", rec_d[12], 0);
      check(rec_d[13] == 1, "u1_d13", rec_d[13], 1);

      start_op(52'h9_1234_5678_9ABC, 1'b0);
      wait_idx(5);
      dig_ready_i = 1'b0;
      op_b_i      = 52'hF_EDCB_A987_6543;
      op_valid_i  = 1'b1;
      repeat (3) begin
         @(posedge clk_i); #1;
         check(dig_idx_o == 4'd5, "stall_idx", longint'(dig_idx_o), 5);
         check(!op_ready_o, "stall_op_ready", longint'(op_ready_o), 0);
      end
      op_valid_i = 1'b0;
      finish_op(1'b0);

      start_op(52'h8_7654_3210_FEDC, 1'b1);
      wait_idx(7);
      #2 rst_ni = 1'b0;
      #1 check(pack_out() == 12'h800, "async_reset", longint'(pack_out()), 64'h800);
      @(posedge clk_i); @(posedge clk_i); #1;
      rst_ni = 1'b1;
      start_op(52'h0_0000_0000_0088, 1'b1);
      finish_op(1'b0);
      check(rec_d[0] == -8, "post_reset_d0", rec_d[0], -8);
      check(rec_d[1] == -7, "post_reset_d1", rec_d[1], -7);
      check(rec_d[2] == 1, "post_reset_d2", rec_d[2], 1);

      start_op(52'h8_0000_0000_0000, 1'b1);
      finish_op(1'b1);
      start_op(52'h7_FFFF_FFFF_FFFF, 1'b1);
      finish_op(1'b1);
      start_op(52'h8_8888_8888_8888, 1'b0);
      finish_op(1'b1);
      for (int n = 0; n < 20; n++) begin
         rb = {$urandom(), $urandom()} & {WIDTH{1'b1}};
         start_op(rb, 1'($urandom_range(0, 1)));
         finish_op(1'b1);
      end

      repeat (2) @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
